backprop_weight_updater: RTL

- Backward-pass engine for one learning neuron; runs the opposite direction to the forward multiply/sum/threshold path.
- Accepts an error delta from the backprop-start stage, in the same numeric format and Q format as the neuron inputs, which are treated as that neuron's own inputs.
- Walks the inputs plus the bias one index per cycle:
  - streams the back-propagated error for each input to the upstream layer;
  - updates the weight register file in place.
- Exposes all weights as a flat vector for the forward multiplier.

---
 rtl/backprop_weight_updater.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/backprop_weight_updater.sv
`default_nettype none
// ============================================================================
// Module   : backprop_weight_updater
// Purpose  : Backward pass for one neuron: streams back-propagated error and
//            updates the weight file (inputs then bias) one index per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module backprop_weight_updater #(
    parameter int           N_INPUTS    = 32,
    parameter int           W           = 16,
    parameter int           F           = 8,
    parameter logic [W-1:0] INIT_WEIGHT = 16'h0080
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [W-1:0]                         delta,
    input  logic [W-1:0]                         lr,
    input  logic [N_INPUTS*W-1:0]                in_flat,
    input  logic [N_INPUTS-1:0]                  enabled,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 back_valid,
    output logic [$clog2(N_INPUTS+1)-1:0]        back_idx,
    output logic [W-1:0]                         back_data,
    output logic [(N_INPUTS+1)*W-1:0]            weights_flat
);

    localparam int IW = $clog2(N_INPUTS + 1);
    localparam int NW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int W2 = 2 * W;

    localparam logic [IW-1:0]        c_LAST  = IW'(N_INPUTS);
    localparam logic signed [W-1:0]  c_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  c_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W2-1:0] c_MAX_P = {{W{1'b0}}, c_MAX};
    localparam logic signed [W2-1:0] c_MIN_P = {{W{1'b1}}, c_MIN};

    function automatic logic signed [W-1:0] f_sat_shift(input logic signed [W2-1:0] p);
        logic signed [W2-1:0] s;
        logic signed [W-1:0]  r;
        s = p >>> F;
        if (s > c_MAX_P)      r = c_MAX;
        else if (s < c_MIN_P) r = c_MIN;
        else                  r = s[W-1:0];
        return r;
    endfunction

    // One guard bit: overflow shows up as disagreement between the top two bits.
    function automatic logic signed [W-1:0] f_sat_add(input logic signed [W-1:0] a,
                                                      input logic signed [W-1:0] b);
        logic signed [W:0]   sum;
        logic signed [W-1:0] r;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) r = sum[W] ? c_MIN : c_MAX;
        else                    r = sum[W-1:0];
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;

    logic signed [W-1:0]   r_delta;
    logic signed [W-1:0]   r_lr;
    logic [N_INPUTS*W-1:0] r_in;
    logic [N_INPUTS-1:0]   r_en;
    logic [IW-1:0]         r_idx;
    logic [W-1:0]          r_w [N_INPUTS+1];

    logic                  r_s1_valid;
    logic [IW-1:0]         r_s1_idx;
    logic                  r_s1_en;
    logic                  r_s1_bias;
    logic signed [W-1:0]   r_s1_bd;
    logic signed [W-1:0]   r_s1_grad;

    logic                  w_is_bias;
    logic [NW-1:0]         w_sel;
    logic                  w_en_cur;
    logic signed [W-1:0]   w_w_old;
    logic signed [W-1:0]   w_in_cur;
    logic signed [W2-1:0]  w_bd_prod;
    logic signed [W2-1:0]  w_grad_prod;
    logic signed [W-1:0]   w_bd;
    logic signed [W-1:0]   w_grad;
    logic signed [W2-1:0]  w_step_prod;
    logic signed [W-1:0]   w_step;
    logic signed [W-1:0]   w_w_cur;
    logic signed [W-1:0]   w_w_new;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN:   if (w_is_bias) w_state_next = S_FLUSH;
            S_FLUSH: w_state_next = S_DONE;
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stage 1: read the pre-update weight and form back_data and the gradient.
    // On the bias index the low bits of r_idx alias input 0; that lane is masked.
    assign w_is_bias   = (r_idx == c_LAST);
    assign w_sel       = r_idx[NW-1:0];
    assign w_en_cur    = w_is_bias | r_en[w_sel];
    assign w_w_old     = r_w[r_idx];
    assign w_in_cur    = r_in[w_sel*W +: W];
    assign w_bd_prod   = W2'(r_delta) * W2'(w_w_old);
    assign w_grad_prod = W2'(r_delta) * W2'(w_in_cur);
    assign w_bd        = (w_en_cur && !w_is_bias) ? f_sat_shift(w_bd_prod) : '0;
    assign w_grad      = w_is_bias ? r_delta : f_sat_shift(w_grad_prod);

    // Stage 2: scale by learning rate and write back; indices never collide
    // with stage 1 because the walk moves forward every cycle.
    assign w_step_prod = W2'(r_lr) * W2'(r_s1_grad);
    assign w_step      = f_sat_shift(w_step_prod);
    assign w_w_cur     = r_w[r_s1_idx];
    assign w_w_new     = f_sat_add(w_w_cur, w_step);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_delta    <= '0;
            r_lr       <= '0;
            r_in       <= '0;
            r_en       <= '0;
            r_idx      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_en    <= 1'b0;
            r_s1_bias  <= 1'b0;
            r_s1_bd    <= '0;
            r_s1_grad  <= '0;
            back_valid <= 1'b0;
            back_idx   <= '0;
            back_data  <= '0;
            for (int i = 0; i <= N_INPUTS; i++) r_w[i] <= INIT_WEIGHT;
        end else begin
            if (w_accept) begin
                r_delta <= delta;
                r_lr    <= lr;
                r_in    <= in_flat;
                r_en    <= enabled;
                r_idx   <= '0;
            end else if (r_state == S_RUN && !w_is_bias) begin
                r_idx <= r_idx + 1'b1;
            end

            r_s1_valid <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_s1_idx  <= r_idx;
                r_s1_en   <= w_en_cur;
                r_s1_bias <= w_is_bias;
                r_s1_bd   <= w_bd;
                r_s1_grad <= w_grad;
            end

            if (r_s1_valid && r_s1_en) r_w[r_s1_idx] <= w_w_new;

            back_valid <= r_s1_valid && !r_s1_bias;
            if (r_s1_valid && !r_s1_bias) begin
                back_idx  <= r_s1_idx;
                back_data <= r_s1_bd;
            end
        end
    end

    for (genvar gi = 0; gi <= N_INPUTS; gi++) begin : g_flat
        assign weights_flat[gi*W +: W] = r_w[gi];
    end

endmodule
`default_nettype wire
